// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and requester encodings for the register-file write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

endpackage

// File: rtl/reg_write_arbiter_scoreboard.sv
// Per-register pending-write counters: claim at issue, release at commit.
module rw_scoreboard
    import reg_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_addr,
    output logic              claim_ready,
    output logic [NREG-1:0]   busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;

    assign claim_ready = (cnt[claim_addr] != CNT_MAX);

    // A commit to an idle register is a plain write; the counter floors at zero.
    always_comb begin
        inc  = '0;
        dec  = '0;
        busy = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc[r]  = claim_valid && claim_ready && (claim_addr == ADDR_W'(r));
            dec[r]  = commit_valid && (commit_addr == ADDR_W'(r)) && (cnt[r] != '0);
            busy[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec[r] && !inc[r]) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load/mem writeback.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_ready,
    output logic [NREG-1:0]   busy,
    output logic              regwrite,
    output logic [ADDR_W-1:0] address_dest,
    output logic [DATA_W-1:0] data_dest
);

    req_id_t    rr_last;
    logic [1:0] grant;
    logic       xfer;

    // rr_last resets to MEM so that the ALU requester wins the first contended grant.
    always_comb begin
        grant = '0;
        if (!reset) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (rr_last == REQ_ALU) ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last      <= REQ_MEM;
            regwrite     <= 1'b0;
            address_dest <= '0;
            data_dest    <= '0;
        end else begin
            regwrite <= xfer;
            if (xfer) begin
                rr_last      <= grant[1] ? REQ_MEM : REQ_ALU;
                address_dest <= grant[1] ? req_addr1 : req_addr0;
                data_dest    <= grant[1] ? req_data1 : req_data0;
            end
        end
    end

    rw_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .claim_valid  (claim_valid),
        .claim_addr   (claim_addr),
        .commit_valid (regwrite),
        .commit_addr  (address_dest),
        .claim_ready  (claim_ready),
        .busy         (busy)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: stimulus queues expected register-file writes, monitor checks them.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [2:0]  req_addr0;
    logic [15:0] req_data0;
    logic [2:0]  req_addr1;
    logic [15:0] req_data1;
    logic [1:0]  req_ready;
    logic        claim_valid;
    logic [2:0]  claim_addr;
    logic        claim_ready;
    logic [7:0]  busy;
    logic        regwrite;
    logic [2:0]  address_dest;
    logic [15:0] data_dest;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q [$];

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr0    (req_addr0),
        .req_data0    (req_data0),
        .req_addr1    (req_addr1),
        .req_data1    (req_data1),
        .req_ready    (req_ready),
        .claim_valid  (claim_valid),
        .claim_addr   (claim_addr),
        .claim_ready  (claim_ready),
        .busy         (busy),
        .regwrite     (regwrite),
        .address_dest (address_dest),
        .data_dest    (data_dest)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the next queued expectation.
    always @(negedge clk) begin
        if (regwrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         address_dest, data_dest);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({address_dest, data_dest} !== e) begin
                    errors++;
                    $display("FAIL write_data: got %0h/%0h expected %0h/%0h",
                             address_dest, data_dest, e[18:16], e[15:0]);
                end
            end
        end
    end

    // Single ALU write; returns at the negedge after the commit edge.
    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        req_valid = 2'b01; req_addr0 = a; req_data0 = d;
        #1 chk("write_ready", req_ready, 2'b01);
        exp_q.push_back({a, d});
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic do_claim(input logic [2:0] a, input logic exp_ready);
        claim_valid = 1'b1; claim_addr = a;
        #1 chk("claim_ready", claim_ready, exp_ready);
        @(negedge clk);
        claim_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_addr0 = '0; req_data0 = '0;
        req_addr1 = '0; req_data1 = '0; claim_valid = 1'b0; claim_addr = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_addr", address_dest, 0);
        chk("rst_data", data_dest, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b0;

        // 1: single ALU write
        req_valid = 2'b01; req_addr0 = 3'd3; req_data0 = 16'hBEEF;
        #1 chk("t1_grant", req_ready, 2'b01);
        exp_q.push_back({3'd3, 16'hBEEF});
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("t1_regwrite", regwrite, 1);
        @(negedge clk);
        #1 chk("t1_idle", regwrite, 0);

        // 2: contention, alternate grants from a fresh pointer
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        req_valid = 2'b11; req_addr0 = 3'd1; req_data0 = 16'h1111;
        req_addr1 = 3'd2; req_data1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("t2_regwrite", regwrite, 1);
            if (k % 2 == 0) exp_q.push_back({3'd1, 16'h1111});
            else            exp_q.push_back({3'd2, 16'h2222});
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1 chk("t2_last_regwrite", regwrite, 1);
        @(negedge clk);
        #1 chk("t2_idle", regwrite, 0);

        // 3: two claims on r5, released by two commits
        do_claim(3'd5, 1'b1);
        do_claim(3'd5, 1'b1);
        chk("t3_busy_claimed", busy[5], 1);
        do_write(3'd5, 16'h0505);
        chk("t3_busy_one_left", busy[5], 1);
        do_write(3'd5, 16'h0555);
        chk("t3_busy_clear", busy[5], 0);

        // 4: claim r4 on the same edge as a commit to r4
        do_claim(3'd4, 1'b1);
        req_valid = 2'b01; req_addr0 = 3'd4; req_data0 = 16'h4444;
        exp_q.push_back({3'd4, 16'h4444});
        @(negedge clk);
        req_valid = 2'b00;
        do_claim(3'd4, 1'b1);
        chk("t4_busy_held", busy[4], 1);
        do_write(3'd4, 16'h4040);
        chk("t4_busy_clear", busy[4], 0);

        // 5: saturate r6 then drain it
        do_claim(3'd6, 1'b1);
        do_claim(3'd6, 1'b1);
        do_claim(3'd6, 1'b1);
        do_claim(3'd6, 1'b0);
        chk("t5_busy_sat", busy[6], 1);
        do_write(3'd6, 16'h0006);
        do_write(3'd6, 16'h0066);
        chk("t5_busy_one_left", busy[6], 1);
        do_write(3'd6, 16'h0666);
        chk("t5_busy_clear", busy[6], 0);

        // unclaimed commit leaves r7 at zero; a following claim must show busy
        do_write(3'd7, 16'h7777);
        chk("floor_busy", busy[7], 0);
        do_claim(3'd7, 1'b1);
        chk("floor_claim_busy", busy[7], 1);
        do_write(3'd7, 16'h7070);
        chk("floor_release", busy[7], 0);

        // 6: reset with both valid and a write in flight
        do_claim(3'd3, 1'b1);
        req_valid = 2'b11; req_addr0 = 3'd1; req_data0 = 16'hAAAA;
        req_addr1 = 3'd2; req_data1 = 16'hBBBB;
        #1 chk("t6_grant_mem", req_ready, 2'b10);
        exp_q.push_back({3'd2, 16'hBBBB});
        @(negedge clk);
        reset = 1'b1;
        #1 chk("t6_reset_regwrite_in", regwrite, 1);
        chk("t6_reset_ready", req_ready, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_regwrite_cleared", regwrite, 0);
        chk("t6_busy_cleared", busy, 0);
        #1 chk("t6_grant_alu_first", req_ready, 2'b01);
        exp_q.push_back({3'd1, 16'hAAAA});
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
